icache_sa: RTL and testbench
============================

# icache_sa

N-way set-associative, blocking, read-only instruction cache with parametrised geometry, per-set round-robin replacement, multi-beat line refill and a walking flush. It sits between the fetch stage and the memory/bus interface. It is the successor to the fixed direct-mapped icache configuration.

## Interface
Parameters:
- WDSZ, 32, word/address width.
- WAYS, 2, associativity (power of 2, ≥1; 1 = direct-mapped).
- SETS, 64, sets per way (power of 2).
- LINE_WORDS, 16, words per line (power of 2, multiple of RBKSZ).
- RBKSZ, 4, words per memory read beat.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_addr  in  WDSZ  byte address; bits [1:0] ignored.
- resp_valid  out  1  one-cycle pulse; no backpressure.
- resp_data  out  WDSZ  fetched word.
- flush  in  1  level/pulse; invalidates all lines.
- flush_busy  out  1  flush pending or in progress.
- mem_req_valid  out  1  line refill request.
- mem_req_ready  in  1  refill request handshake.
- mem_req_addr  out  WDSZ  line-aligned address (offset bits zero).
- mem_resp_valid  in  1  one refill beat.
- mem_resp_data  in  RBKSZ*WDSZ  beat; word 0 in LSBs.

## Operation
- Address split: offset = log2(LINE_WORDS)+2 bits, index = log2(SETS) bits, tag = remainder.
- Storage per way/set: tag, valid; data LINE_WORDS×WDSZ. Per set: rr pointer, log2(WAYS) bits (absent when WAYS=1).
- FSM states: IDLE, LOOKUP, MISS_REQ, REFILL, FLUSH.
- IDLE: req_ready=1 unless flush pending. Accept → latch address, go to LOOKUP.
- LOOKUP: compare the latched tag against all ways of the set.
  - Hit: resp_valid=1 with the word. req_ready=1, so a new request may be accepted (stay in LOOKUP); otherwise go to IDLE. A pending flush goes to FLUSH instead, with req_ready=0.
  - Miss: req_ready=0. Choose the victim and go to MISS_REQ.
- Victim: lowest-index invalid way; if all are valid, the way at rr pointer.
- MISS_REQ: mem_req_valid=1, address held stable until mem_req_ready, then go to REFILL with beat counter=0.
- REFILL: each mem_resp_valid writes RBKSZ words to victim words [cnt*RBKSZ +: RBKSZ] and increments cnt.
  - On the last beat (cnt = LINE_WORDS/RBKSZ−1), write tag, set valid, and advance rr[set] modulo WAYS (only if the victim was chosen by rr).
  - Then go to LOOKUP, which hits.
- flush: sampled high in any cycle sets flush_pending. flush_busy = flush_pending or state==FLUSH.
  - An in-flight refill completes first. The response for that request is still delivered.
- FLUSH: clears valid for all ways of one set per cycle, for SETS cycles, and resets rr pointers to 0. Then go to IDLE and clear flush_busy.
  - flush asserted again during FLUSH re-arms pending, so one more full walk follows.
- Reset: state=IDLE, all valid=0, rr=0, flush_pending=0. Beats arriving after reset are ignored.

## Timing
- Reset values: req_ready=1 (IDLE), resp_valid=0, resp_data=0, mem_req_valid=0, mem_req_addr=0, flush_busy=0.
- Hit: accept at cycle t → resp_valid at t+1. Back-to-back hits give 1 word/cycle.
- Miss: accept at t → mem_req_valid at t+2. After the last beat at cycle r → resp_valid at r+1.
- Flush from IDLE: high at t → FLUSH at t+1..t+SETS → req_ready=1 at t+SETS+1.
- mem_resp_valid outside REFILL is ignored.

## Structure
- Package icache_sa_pkg holds:
  - default parameters;
  - typedefs word_t, tag_t, index_t, offset_t, way_t;
  - the packed addr_t {tag, index, woff, boff};
  - the per-line overhead_t {tag, valid};
  - the state enum.
- Sub-module icache_way_select (combinational): inputs are the set's tags/valids, the latched tag and the rr pointer; outputs are hit, hit_way and victim_way.

## Test plan
- Cold miss 0x0000_1040 → mem_req_addr=0x0000_1040, 4 beats, resp_data = beat0 word 0; fetch 0x0000_1044 → hit, resp_valid 1 cycle after accept.
- Hits 0x1040..0x107C, req_valid held high → 16 consecutive resp_valid, no mem_req_valid.
- Conflict in set 1: fill 0x1040 (way0), then 0x2040 (way1), then 0x3040 → evicts way0 (rr). Refetch 0x2040 → hit; refetch 0x1040 → miss.
- flush pulsed during beat 2 of a refill → refill completes and resp is delivered, then flush_busy held 64 cycles; next fetch of 0x1040 → miss.
- reset_n low during REFILL → outputs return to reset values immediately; 0x1040 afterwards → fresh miss; stray beats ignored.
- WAYS=1, SETS=16, LINE_WORDS=4, RBKSZ=4 → single-beat refill. 0x0040 and 0x0440 alternate → always miss.

Source files
------------

// File: rtl/icache_sa_pkg.sv
// rtl/icache_sa_pkg.sv - geometry defaults, address/line types and FSM states for icache_sa
package icache_sa_pkg;
  localparam int WDSZ_DEF       = 32;
  localparam int WAYS_DEF       = 2;
  localparam int SETS_DEF       = 64;
  localparam int LINE_WORDS_DEF = 16;
  localparam int RBKSZ_DEF      = 4;
  localparam int BOFF_W         = 2;
  localparam int WOFF_W_DEF     = $clog2(LINE_WORDS_DEF);
  localparam int IDX_W_DEF      = $clog2(SETS_DEF);
  localparam int TAG_W_DEF      = WDSZ_DEF - IDX_W_DEF - WOFF_W_DEF - BOFF_W;
  localparam int WAY_W_DEF      = (WAYS_DEF > 1) ? $clog2(WAYS_DEF) : 1;

  typedef logic [WDSZ_DEF-1:0]   word_t;
  typedef logic [TAG_W_DEF-1:0]  tag_t;
  typedef logic [IDX_W_DEF-1:0]  index_t;
  typedef logic [WOFF_W_DEF-1:0] offset_t;
  typedef logic [WAY_W_DEF-1:0]  way_t;

  typedef struct packed {
    tag_t              tag;
    index_t            index;
    offset_t           woff;
    logic [BOFF_W-1:0] boff;
  } addr_t;

  typedef struct packed {
    tag_t tag;
    logic valid;
  } overhead_t;

  typedef enum logic [2:0] {ST_IDLE, ST_LOOKUP, ST_MISS_REQ, ST_REFILL, ST_FLUSH} state_t;

  // Width of a selector for n items; a single item still needs one bit.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/icache_way_select.sv
// rtl/icache_way_select.sv - tag match across one set and victim choice (lowest invalid, else rr)
module icache_way_select #(
  parameter int WAYS  = 2,
  parameter int TAG_W = 20,
  parameter int WAY_W = 1
) (
  input  logic [WAYS*TAG_W-1:0] tags_i,
  input  logic [WAYS-1:0]       valids_i,
  input  logic [TAG_W-1:0]      tag_i,
  input  logic [WAY_W-1:0]      rr_i,
  output logic                  hit_o,
  output logic [WAY_W-1:0]      hit_way_o,
  output logic [WAY_W-1:0]      victim_way_o
);
  always_comb begin
    hit_o        = 1'b0;
    hit_way_o    = '0;
    victim_way_o = rr_i;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit_o && valids_i[w] && (tags_i[w*TAG_W +: TAG_W] == tag_i)) begin
        hit_o     = 1'b1;
        hit_way_o = WAY_W'(w);
      end
    end
    // Descending scan so the lowest-index invalid way is the last one written.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valids_i[w]) victim_way_o = WAY_W'(w);
    end
  end
endmodule

// File: rtl/icache_sa.sv
// rtl/icache_sa.sv - blocking set-associative read-only instruction cache with line refill and walking flush
module icache_sa import icache_sa_pkg::*; #(
  parameter int WDSZ       = WDSZ_DEF,
  parameter int WAYS       = WAYS_DEF,
  parameter int SETS       = SETS_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int RBKSZ      = RBKSZ_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [WDSZ-1:0]       req_addr,
  output logic                  resp_valid,
  output logic [WDSZ-1:0]       resp_data,
  input  logic                  flush,
  output logic                  flush_busy,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [WDSZ-1:0]       mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [RBKSZ*WDSZ-1:0] mem_resp_data
);
  localparam int WOFF_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WOFF_W + BOFF_W;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = WDSZ - OFF_W - IDX_W;
  localparam int WAY_W  = min1_clog2(WAYS);
  localparam int BEATS  = LINE_WORDS / RBKSZ;
  localparam int CNT_W  = min1_clog2(BEATS);
  localparam int AQ_W   = WDSZ - BOFF_W;

  state_t                 state_q, state_d;
  logic [AQ_W-1:0]        addr_q, addr_d;
  logic [WAY_W-1:0]       victim_q, victim_d;
  logic                   victim_rr_q, victim_rr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       fcnt_q, fcnt_d;
  logic                   flush_pending_q, flush_pending_d;

  logic [TAG_W-1:0]       tag_q  [WAYS][SETS];
  logic [SETS-1:0]        valid_q [WAYS];
  logic [WDSZ-1:0]        data_q [WAYS][SETS][LINE_WORDS];
  logic [WAY_W-1:0]       rr_q   [SETS];

  logic [WOFF_W-1:0]      woff;
  logic [IDX_W-1:0]       idx;
  logic [TAG_W-1:0]       tag;
  logic [WAYS*TAG_W-1:0]  set_tags;
  logic [WAYS-1:0]        set_valids;
  logic                   hit;
  logic [WAY_W-1:0]       hit_way, victim_way, rr_next;
  logic                   flush_pend, start_flush, refill_beat, refill_last;
  logic                   unused_boff;

  assign unused_boff = ^req_addr[BOFF_W-1:0];
  assign woff        = addr_q[0 +: WOFF_W];
  assign idx         = addr_q[WOFF_W +: IDX_W];
  assign tag         = addr_q[AQ_W-1 -: TAG_W];
  assign flush_pend  = flush_pending_q | flush;
  assign rr_next     = (rr_q[idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[idx] + 1'b1;

  always_comb begin
    set_tags   = '0;
    set_valids = '0;
    for (int w = 0; w < WAYS; w++) begin
      set_tags[w*TAG_W +: TAG_W] = tag_q[w][idx];
      set_valids[w]              = valid_q[w][idx];
    end
  end

  icache_way_select #(.WAYS(WAYS), .TAG_W(TAG_W), .WAY_W(WAY_W)) u_way_select (
    .tags_i      (set_tags),
    .valids_i    (set_valids),
    .tag_i       (tag),
    .rr_i        (rr_q[idx]),
    .hit_o       (hit),
    .hit_way_o   (hit_way),
    .victim_way_o(victim_way)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    victim_d      = victim_q;
    victim_rr_d   = victim_rr_q;
    cnt_d         = cnt_q;
    fcnt_d        = fcnt_q;
    start_flush   = 1'b0;
    refill_beat   = 1'b0;
    refill_last   = 1'b0;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    mem_req_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = !flush_pend;
        if (flush_pend) begin
          state_d     = ST_FLUSH;
          start_flush = 1'b1;
          fcnt_d      = '0;
        end else if (req_valid) begin
          addr_d  = req_addr[WDSZ-1:BOFF_W];
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (hit) begin
          resp_valid = 1'b1;
          if (flush_pend) begin
            state_d     = ST_FLUSH;
            start_flush = 1'b1;
            fcnt_d      = '0;
          end else begin
            req_ready = 1'b1;
            if (req_valid) addr_d = req_addr[WDSZ-1:BOFF_W];
            else           state_d = ST_IDLE;
          end
        end else begin
          victim_d    = victim_way;
          victim_rr_d = &set_valids;
          state_d     = ST_MISS_REQ;
        end
      end
      ST_MISS_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = ST_REFILL;
          cnt_d   = '0;
        end
      end
      ST_REFILL: begin
        if (mem_resp_valid) begin
          refill_beat = 1'b1;
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BEATS - 1)) begin
            refill_last = 1'b1;
            state_d     = ST_LOOKUP;
          end
        end
      end
      ST_FLUSH: begin
        fcnt_d = fcnt_q + 1'b1;
        if (fcnt_q == IDX_W'(SETS - 1)) begin
          if (flush_pend) begin
            start_flush = 1'b1;
            fcnt_d      = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A flush request is consumed only when a walk actually starts; any later pulse re-arms it.
  assign flush_pending_d = start_flush ? 1'b0 : flush_pend;
  assign flush_busy      = flush_pending_q | (state_q == ST_FLUSH);
  assign resp_data       = resp_valid ? data_q[hit_way][idx][woff] : '0;
  assign mem_req_addr    = mem_req_valid ? {tag, idx, OFF_W'(0)} : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      victim_q        <= '0;
      victim_rr_q     <= 1'b0;
      cnt_q           <= '0;
      fcnt_q          <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      victim_q        <= victim_d;
      victim_rr_q     <= victim_rr_d;
      cnt_q           <= cnt_d;
      fcnt_q          <= fcnt_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else if (state_q == ST_FLUSH) begin
      for (int w = 0; w < WAYS; w++) valid_q[w][fcnt_q] <= 1'b0;
      rr_q[fcnt_q] <= '0;
    end else if (refill_last) begin
      valid_q[victim_q][idx] <= 1'b1;
      if (victim_rr_q) rr_q[idx] <= rr_next;
    end
  end

  always_ff @(posedge clock) begin
    if (refill_beat) begin
      for (int i = 0; i < RBKSZ; i++) begin
        data_q[victim_q][idx][WOFF_W'(int'(cnt_q) * RBKSZ + i)] <= mem_resp_data[i*WDSZ +: WDSZ];
      end
    end
    if (refill_last) tag_q[victim_q][idx] <= tag;
  end
endmodule

// File: tb/tb_icache_sa.sv
// tb/tb_icache_sa.sv - scoreboard bench for icache_sa (default geometry plus a direct-mapped instance)
module tb_icache_sa;
  logic          clock = 1'b0;
  logic          reset_n;
  logic          req_valid, req_ready, resp_valid, flush, flush_busy;
  logic [31:0]   req_addr, resp_data, mem_req_addr;
  logic          mem_req_valid, mem_req_ready, mem_resp_valid;
  logic [127:0]  mem_resp_data;

  logic          b_req_valid, b_req_ready, b_resp_valid, b_flush, b_flush_busy;
  logic [31:0]   b_req_addr, b_resp_data, b_mem_req_addr;
  logic          b_mem_req_valid, b_mem_req_ready, b_mem_resp_valid;
  logic [127:0]  b_mem_resp_data;

  int            checks = 0;
  int            failures = 0;
  logic [31:0]   exp_q[$];

  always #5 clock = ~clock;

  icache_sa dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .resp_valid(resp_valid), .resp_data(resp_data), .flush(flush),
    .flush_busy(flush_busy), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  icache_sa #(.WAYS(1), .SETS(16), .LINE_WORDS(4), .RBKSZ(4)) dut_dm (
    .clock(clock), .reset_n(reset_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_addr(b_req_addr), .resp_valid(b_resp_valid), .resp_data(b_resp_data), .flush(b_flush),
    .flush_busy(b_flush_busy), .mem_req_valid(b_mem_req_valid), .mem_req_ready(b_mem_req_ready),
    .mem_req_addr(b_mem_req_addr), .mem_resp_valid(b_mem_resp_valid), .mem_resp_data(b_mem_resp_data)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [127:0] beat_data(input logic [31:0] line, input int b);
    logic [127:0] d;
    for (int i = 0; i < 4; i++) d[i*32 +: 32] = word_of(line + 32'((b * 4 + i) * 4));
    return d;
  endfunction

  // One fetch on the default instance, with an optional flush pulse or reset at a given refill beat.
  task automatic fetch(input logic [31:0] addr, input bit exp_hit, input int flush_beat,
                       input int reset_beat, input string name);
    int acc_cyc, mreq_cyc, last_cyc, beat, ready_wait;
    bit accepted, done, in_refill, start_refill;
    logic [31:0] line, exp;
    line = {addr[31:6], 6'b0};
    accepted = 0; done = 0; in_refill = 0; start_refill = 0;
    beat = 0; ready_wait = 0; acc_cyc = -1; mreq_cyc = -1; last_cyc = -1;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clock);
      req_valid      = !accepted;
      req_addr       = addr;
      mem_req_ready  = (ready_wait >= 2);
      mem_resp_valid = in_refill;
      mem_resp_data  = in_refill ? beat_data(line, beat) : '0;
      flush          = in_refill && (beat == flush_beat);
      if (in_refill && beat == reset_beat) begin
        reset_n = 1'b0; mem_resp_valid = 1'b0; flush = 1'b0;
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr, flush_busy} !==
            {1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0}) begin
          failures++;
          $display("FAIL %s_async_reset rdy=%b rv=%b rd=%h mv=%b ma=%h fb=%b exp 1 0 0 0 0 0",
                   name, req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr, flush_busy);
        end
        if (accepted) exp_q.delete(exp_q.size() - 1);
        done = 1;
      end else begin
        #1;
        if (resp_valid) begin
          checks++;
          if (!accepted || exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s_unexpected_resp got=%h exp=no response", name, resp_data);
          end else begin
            exp = exp_q.pop_front();
            if (resp_data !== exp) begin
              failures++;
              $display("FAIL %s_data got=%h exp=%h", name, resp_data, exp);
            end
            checks++;
            if (exp_hit && cyc != acc_cyc + 1) begin
              failures++;
              $display("FAIL %s_hit_latency got=%0d exp=%0d", name, cyc - acc_cyc, 1);
            end else if (!exp_hit && cyc != last_cyc + 1) begin
              failures++;
              $display("FAIL %s_refill_latency got=%0d exp=%0d", name, cyc - last_cyc, 1);
            end
          end
          done = 1;
        end
        if (mem_req_valid) begin
          if (mreq_cyc < 0) begin
            mreq_cyc = cyc;
            checks++;
            if (exp_hit || cyc != acc_cyc + 2) begin
              failures++;
              $display("FAIL %s_mem_req_timing got=%0d exp=%0d hit_expected=%0b",
                       name, cyc - acc_cyc, 2, exp_hit);
            end
          end
          checks++;
          if (mem_req_addr !== line) begin
            failures++;
            $display("FAIL %s_mem_req_addr got=%h exp=%h", name, mem_req_addr, line);
          end
          if (mem_req_ready) start_refill = 1;
          else ready_wait++;
        end
        if (in_refill) begin
          beat++;
          if (beat == 4) begin in_refill = 0; last_cyc = cyc; end
        end
        if (start_refill) begin in_refill = 1; start_refill = 0; end
        if (!accepted && req_valid && req_ready) begin
          accepted = 1; acc_cyc = cyc;
          exp_q.push_back(word_of(addr));
        end
      end
    end
    req_valid = 0; mem_resp_valid = 0; mem_req_ready = 0; flush = 0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s_timeout got=no response exp=response within 400 cycles", name);
    end
  endtask

  task automatic test_reset;
    @(negedge clock); #1;
    checks++; if (req_ready !== 1'b1)    begin failures++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0)   begin failures++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_data !== 32'h0)   begin failures++; $display("FAIL rst_resp_data got=%h exp=0", resp_data); end
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_mem_req_valid got=%b exp=0", mem_req_valid); end
    checks++; if (mem_req_addr !== 32'h0) begin failures++; $display("FAIL rst_mem_req_addr got=%h exp=0", mem_req_addr); end
    checks++; if (flush_busy !== 1'b0)   begin failures++; $display("FAIL rst_flush_busy got=%b exp=0", flush_busy); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_cold_miss;
    fetch(32'h0000_1040, 1'b0, -1, -1, "cold_miss");
    fetch(32'h0000_1044, 1'b1, -1, -1, "hit_after_fill");
  endtask

  task automatic test_back_to_back;
    int k, nresp, first, lastr, acc0;
    bit mreq_seen;
    logic [31:0] exp;
    k = 0; nresp = 0; first = -1; lastr = -1; acc0 = -1; mreq_seen = 0;
    for (int cyc = 0; cyc < 100 && nresp < 16; cyc++) begin
      @(negedge clock);
      req_valid = (k < 16);
      req_addr  = 32'h0000_1040 + 32'(k * 4);
      #1;
      if (resp_valid) begin
        checks++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        if (resp_data !== exp) begin
          failures++;
          $display("FAIL b2b_data[%0d] got=%h exp=%h", nresp, resp_data, exp);
        end
        if (first < 0) first = cyc;
        lastr = cyc;
        nresp++;
      end
      if (mem_req_valid) mreq_seen = 1;
      if (req_valid && req_ready) begin
        exp_q.push_back(word_of(req_addr));
        if (k == 0) acc0 = cyc;
        k++;
      end
    end
    req_valid = 0;
    checks++; if (nresp != 16) begin failures++; $display("FAIL b2b_count got=%0d exp=16", nresp); end
    checks++; if (first != acc0 + 1) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=1", first - acc0); end
    checks++; if (lastr - first != 15) begin failures++; $display("FAIL b2b_consecutive got=%0d exp=15", lastr - first); end
    checks++; if (mreq_seen) begin failures++; $display("FAIL b2b_no_mem_req got=1 exp=0"); end
  endtask

  task automatic test_conflict;
    fetch(32'h0000_2040, 1'b0, -1, -1, "conflict_fill_way1");
    fetch(32'h0000_3040, 1'b0, -1, -1, "conflict_evict_rr");
    fetch(32'h0000_2040, 1'b1, -1, -1, "conflict_survivor_hit");
    fetch(32'h0000_1040, 1'b0, -1, -1, "conflict_evicted_miss");
  endtask

  task automatic test_flush_during_refill;
    int busy;
    bit ready_seen;
    checks++;
    fetch(32'h0000_5040, 1'b0, 2, -1, "flush_refill");
    if (flush_busy !== 1'b1) begin failures++; $display("FAIL flush_busy_at_resp got=%b exp=1", flush_busy); end
    busy = 0; ready_seen = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock); #1;
      if (!flush_busy) break;
      if (req_ready) ready_seen = 1;
      busy++;
    end
    checks++; if (busy != 64) begin failures++; $display("FAIL flush_busy_cycles got=%0d exp=64", busy); end
    checks++; if (ready_seen) begin failures++; $display("FAIL flush_req_ready got=1 exp=0"); end
    fetch(32'h0000_1040, 1'b0, -1, -1, "after_flush_miss");
  endtask

  task automatic test_flush_idle;
    int n;
    @(negedge clock);
    flush = 1'b1;
    #1;
    checks++; if (flush_busy !== 1'b0) begin failures++; $display("FAIL flush_idle_busy_t got=%b exp=0", flush_busy); end
    n = 0;
    for (int c = 1; c < 200; c++) begin
      @(negedge clock);
      flush = 1'b0;
      #1;
      if (req_ready) begin n = c; break; end
    end
    checks++; if (n != 65) begin failures++; $display("FAIL flush_idle_ready_cycle got=%0d exp=65", n); end
    fetch(32'h0000_1044, 1'b0, -1, -1, "flush_idle_miss");
  endtask

  task automatic test_reset_refill;
    fetch(32'h0000_2040, 1'b0, -1, 1, "reset_refill");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      mem_resp_valid = 1'b1;
      mem_resp_data  = {4{32'hDEAD_BEEF}};
      #1;
      checks++;
      if (resp_valid !== 1'b0 || mem_req_valid !== 1'b0 || req_ready !== 1'b1) begin
        failures++;
        $display("FAIL stray_beat_ignored rv=%b mv=%b rdy=%b exp 0 0 1", resp_valid, mem_req_valid, req_ready);
      end
    end
    mem_resp_valid = 1'b0;
    fetch(32'h0000_1040, 1'b0, -1, -1, "post_reset_miss");
  endtask

  task automatic test_direct_mapped;
    logic [31:0] a, line, exp;
    bit acc, done, beat_due, saw_miss;
    for (int k = 0; k < 6; k++) begin
      a = (k % 2 == 1) ? 32'h0000_0440 : 32'h0000_0040;
      line = {a[31:4], 4'h0};
      acc = 0; done = 0; beat_due = 0; saw_miss = 0;
      for (int c = 0; c < 60 && !done; c++) begin
        @(negedge clock);
        b_req_valid      = !acc;
        b_req_addr       = a;
        b_mem_resp_valid = beat_due;
        b_mem_resp_data  = beat_data(line, 0);
        #1;
        if (b_resp_valid) begin
          checks++;
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
          if (b_resp_data !== exp) begin
            failures++;
            $display("FAIL dm_data[%0d] got=%h exp=%h", k, b_resp_data, exp);
          end
          done = 1;
        end
        beat_due = 0;
        if (b_mem_req_valid) begin
          saw_miss = 1;
          beat_due = 1;
          checks++;
          if (b_mem_req_addr !== line) begin
            failures++;
            $display("FAIL dm_mem_req_addr[%0d] got=%h exp=%h", k, b_mem_req_addr, line);
          end
        end
        if (!acc && b_req_valid && b_req_ready) begin
          acc = 1;
          exp_q.push_back(word_of(a));
        end
      end
      b_req_valid = 0; b_mem_resp_valid = 0;
      checks++;
      if (!done || !saw_miss) begin
        failures++;
        $display("FAIL dm_always_miss[%0d] got done=%0b miss=%0b exp 1 1", k, done, saw_miss);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid = 0; req_addr = '0; flush = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
    b_req_valid = 0; b_req_addr = '0; b_flush = 0;
    b_mem_req_ready = 1'b1; b_mem_resp_valid = 0; b_mem_resp_data = '0;
    repeat (3) @(negedge clock);
    test_reset;
    test_cold_miss;
    test_back_to_back;
    test_conflict;
    test_flush_during_refill;
    test_flush_idle;
    test_reset_refill;
    test_direct_mapped;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
